// File: rtl/alu_result_stage.sv
// alu_result_stage: ALUOut holding register downstream of the datapath ALU.
// Captures result + {N,Z,C,V} on a valid/ready handshake, presents it to the
// writeback/PC-select logic, evaluates the RISC-V branch condition from the
// held flags, counts accepted captures and flags overruns (sticky).
// Optional feature macro: ALURES_BRANCH_EN (branch evaluation + its registers).
module alu_result_stage #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_z,
    input  logic             alu_c,
    input  logic             alu_v,
    input  logic             alu_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             is_branch,
    input  logic [2:0]       funct3,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] aluout,
    output logic [3:0]       flags_q,
    output logic             branch_taken,
    output logic             bad_funct3,
    output logic             overrun,
    input  logic             clr_overrun,
    output logic [CNT_W-1:0] acc_count
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    // Held record; flags packed in {N,Z,C,V} order to match flags_q.
    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [3:0]       flags;
    } hold_t;

    state_t state;
    hold_t  hold;
    logic   capture;
    logic   drop;

    // A slot frees up in the same cycle the consumer takes the held value,
    // so streaming with out_ready high never inserts a bubble.
    assign in_ready  = (state == EMPTY) | out_ready;
    assign capture   = in_valid & in_ready;
    assign drop      = in_valid & ~in_ready;
    assign out_valid = (state == FULL);
    assign aluout    = hold.data;
    assign flags_q   = hold.flags;

    // FSM plus held result/flags; a new capture overwrites, otherwise hold.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= EMPTY;
            hold  <= '0;
        end else begin
            if (capture) begin
                state <= FULL;
                hold  <= '{data: alu_result, flags: {alu_n, alu_z, alu_c, alu_v}};
            end else if (state == FULL && out_ready) begin
                state <= EMPTY;
            end
        end
    end

    // Accepted-capture counter, wraps modulo 2^CNT_W.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)     acc_count <= '0;
        else if (capture) acc_count <= acc_count + 1'b1;
    end

    // Sticky overrun; a new overrun in the clearing cycle keeps it set.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)         overrun <= 1'b0;
        else if (drop)        overrun <= 1'b1;
        else if (clr_overrun) overrun <= 1'b0;
    end

`ifdef ALURES_BRANCH_EN
    logic       is_branch_q;
    logic [2:0] funct3_q;
    logic       fl_n, fl_z, fl_c, fl_v;

    assign {fl_n, fl_z, fl_c, fl_v} = hold.flags;

    // Branch qualifiers ride along with the captured result.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            is_branch_q <= 1'b0;
            funct3_q    <= 3'b000;
        end else if (capture) begin
            is_branch_q <= is_branch;
            funct3_q    <= funct3;
        end
    end

    // Branch condition from held flags; only meaningful while a branch is held.
    always_comb begin
        branch_taken = 1'b0;
        bad_funct3   = 1'b0;
        if (out_valid && is_branch_q) begin
            unique case (funct3_q)
                3'b000:  branch_taken = fl_z;            // BEQ
                3'b001:  branch_taken = ~fl_z;           // BNE
                3'b100:  branch_taken = fl_n ^ fl_v;     // BLT
                3'b101:  branch_taken = ~(fl_n ^ fl_v);  // BGE
                3'b110:  branch_taken = ~fl_c;           // BLTU: borrow
                3'b111:  branch_taken = fl_c;            // BGEU: no borrow
                default: bad_funct3   = 1'b1;            // 010/011 undefined
            endcase
        end
    end
`else
    // Branch qualifiers are not used in this build.
    logic unused_branch_in;
    assign unused_branch_in = ^{is_branch, funct3};
    assign branch_taken     = 1'b0;
    assign bad_funct3       = 1'b0;
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed self-checking bench for alu_result_stage (default parameters).
module tb_alu_result_stage;

    localparam int WIDTH = 32;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             reset_n;
    logic [WIDTH-1:0] alu_result;
    logic             alu_z, alu_c, alu_v, alu_n;
    logic             in_valid;
    logic             in_ready;
    logic             is_branch;
    logic [2:0]       funct3;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] aluout;
    logic [3:0]       flags_q;
    logic             branch_taken;
    logic             bad_funct3;
    logic             overrun;
    logic             clr_overrun;
    logic [CNT_W-1:0] acc_count;

    int checks = 0;
    int errors = 0;

    alu_result_stage #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset_n(reset_n),
        .alu_result(alu_result),
        .alu_z(alu_z), .alu_c(alu_c), .alu_v(alu_v), .alu_n(alu_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .is_branch(is_branch), .funct3(funct3),
        .out_valid(out_valid), .out_ready(out_ready),
        .aluout(aluout), .flags_q(flags_q),
        .branch_taken(branch_taken), .bad_funct3(bad_funct3),
        .overrun(overrun), .clr_overrun(clr_overrun),
        .acc_count(acc_count)
    );

    always #5 clk = ~clk;

    // Advance one rising edge; inputs change and outputs are sampled 1ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n     = 1'b0;
        alu_result  = '0;
        {alu_n, alu_z, alu_c, alu_v} = 4'b0000;
        in_valid    = 1'b0;
        is_branch   = 1'b0;
        funct3      = 3'b000;
        out_ready   = 1'b0;
        clr_overrun = 1'b0;
        step();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        alu_result = 32'hDEADBEEF;
        in_valid   = 1'b1;
        step();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || aluout !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL reset_prefill: out_valid=%b aluout=%h want 1 deadbeef", out_valid, aluout);
        end
        // Async reset mid-FULL, no clock edge in between.
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || aluout !== 32'h0 || acc_count !== 8'd0 || in_ready !== 1'b1 ||
            flags_q !== 4'h0 || overrun !== 1'b0 || branch_taken !== 1'b0 || bad_funct3 !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: ov=%b alu=%h cnt=%0d rdy=%b fl=%h or=%b bt=%b bf=%b want 0 0 0 1 0 0 0 0",
                     out_valid, aluout, acc_count, in_ready, flags_q, overrun, branch_taken, bad_funct3);
        end
        // First capture on the first rising edge after release.
        @(negedge clk);
        reset_n    = 1'b1;
        alu_result = 32'h0000_00A5;
        in_valid   = 1'b1;
        step();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || aluout !== 32'hA5 || acc_count !== 8'd1) begin
            errors++;
            $display("FAIL reset_first_capture: ov=%b alu=%h cnt=%0d want 1 a5 1", out_valid, aluout, acc_count);
        end
    endtask

    task automatic test_single();
        do_reset();
        alu_result = 32'h12345678;
        {alu_n, alu_z, alu_c, alu_v} = 4'b0010;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || aluout !== 32'h12345678 || flags_q !== 4'b0010 ||
            in_ready !== 1'b0 || acc_count !== 8'd1) begin
            errors++;
            $display("FAIL single_capture: ov=%b alu=%h fl=%b rdy=%b cnt=%0d want 1 12345678 0010 0 1",
                     out_valid, aluout, flags_q, in_ready, acc_count);
        end
        step();
        checks++;
        if (out_valid !== 1'b1 || aluout !== 32'h12345678) begin
            errors++;
            $display("FAIL single_hold: ov=%b alu=%h want 1 12345678", out_valid, aluout);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            alu_result = i;
            in_valid   = 1'b1;
            step();
            checks++;
            if (out_valid !== 1'b1 || aluout !== i || in_ready !== 1'b1) begin
                errors++;
                $display("FAIL b2b_stream[%0d]: ov=%b alu=%h rdy=%b want 1 %h 1", i, out_valid, aluout, in_ready, i);
            end
        end
        in_valid = 1'b0;
        checks++;
        if (acc_count !== 8'd4 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL b2b_count: cnt=%0d overrun=%b want 4 0", acc_count, overrun);
        end
        step();
        checks++;
        if (out_valid !== 1'b0 || aluout !== 32'd4) begin
            errors++;
            $display("FAIL b2b_drain: ov=%b alu=%h want 0 4", out_valid, aluout);
        end
    endtask

    task automatic test_overrun();
        do_reset();
        alu_result = 32'hAA;
        in_valid   = 1'b1;
        step();
        alu_result = 32'h55;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL ovr_ready: in_ready=%b want 0", in_ready);
        end
        step();
        in_valid = 1'b0;
        checks++;
        if (aluout !== 32'hAA || overrun !== 1'b1 || out_valid !== 1'b1 || acc_count !== 8'd1) begin
            errors++;
            $display("FAIL ovr_set: alu=%h overrun=%b ov=%b cnt=%0d want aa 1 1 1", aluout, overrun, out_valid, acc_count);
        end
        step();
        step();
        checks++;
        if (overrun !== 1'b1) begin
            errors++;
            $display("FAIL ovr_sticky: overrun=%b want 1", overrun);
        end
        clr_overrun = 1'b1;
        in_valid    = 1'b1;
        step();
        in_valid = 1'b0;
        checks++;
        if (overrun !== 1'b1 || aluout !== 32'hAA) begin
            errors++;
            $display("FAIL ovr_set_wins: overrun=%b alu=%h want 1 aa", overrun, aluout);
        end
        step();
        clr_overrun = 1'b0;
        checks++;
        if (overrun !== 1'b0) begin
            errors++;
            $display("FAIL ovr_clear: overrun=%b want 0", overrun);
        end
    endtask

    task automatic test_branch();
        logic [2:0] f3_tab [8]  = '{3'b100, 3'b110, 3'b111, 3'b000, 3'b011, 3'b001, 3'b101, 3'b010};
        logic       tk_tab [8]  = '{1'b1,   1'b0,   1'b1,   1'b0,   1'b0,   1'b1,   1'b0,   1'b0};
        logic       bad_tab [8] = '{1'b0,   1'b0,   1'b0,   1'b0,   1'b1,   1'b0,   1'b0,   1'b1};
        logic       exp_tk, exp_bad;
        do_reset();
        out_ready  = 1'b1;
        // 0xFFFFFFFF - 1 through the ALU: N=1 Z=0 C=1 V=0.
        alu_result = 32'hFFFF_FFFE;
        {alu_n, alu_z, alu_c, alu_v} = 4'b1010;
        is_branch  = 1'b1;
        for (int i = 0; i < 8; i++) begin
            funct3   = f3_tab[i];
            in_valid = 1'b1;
            step();
`ifdef ALURES_BRANCH_EN
            exp_tk  = tk_tab[i];
            exp_bad = bad_tab[i];
`else
            exp_tk  = 1'b0;
            exp_bad = 1'b0;
`endif
            checks++;
            if (branch_taken !== exp_tk || bad_funct3 !== exp_bad || flags_q !== 4'b1010) begin
                errors++;
                $display("FAIL branch_f3_%b: taken=%b bad=%b fl=%b want %b %b 1010",
                         f3_tab[i], branch_taken, bad_funct3, flags_q, exp_tk, exp_bad);
            end
        end
        // Non-branch hold: both qualifiers must read 0 even with funct3=011.
        is_branch = 1'b0;
        funct3    = 3'b011;
        step();
        checks++;
        if (branch_taken !== 1'b0 || bad_funct3 !== 1'b0) begin
            errors++;
            $display("FAIL branch_not_branch: taken=%b bad=%b want 0 0", branch_taken, bad_funct3);
        end
        // BGEU held, then consumed: taken only while out_valid.
        is_branch = 1'b1;
        funct3    = 3'b111;
        step();
        in_valid = 1'b0;
        step();
        checks++;
        if (out_valid !== 1'b0 || branch_taken !== 1'b0) begin
            errors++;
            $display("FAIL branch_after_consume: ov=%b taken=%b want 0 0", out_valid, branch_taken);
        end
    endtask

    task automatic test_counter_wrap();
        do_reset();
        out_ready  = 1'b1;
        in_valid   = 1'b1;
        alu_result = 32'h1;
        for (int i = 0; i < 255; i++) step();
        checks++;
        if (acc_count !== 8'hFF) begin
            errors++;
            $display("FAIL wrap_255: acc_count=%0d want 255", acc_count);
        end
        step();
        in_valid = 1'b0;
        checks++;
        if (acc_count !== 8'h00 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL wrap_256: acc_count=%0d overrun=%b want 0 0", acc_count, overrun);
        end
    endtask

    // Bound the whole run so a stuck design cannot hang the bench.
    initial begin
        #200000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overrun();
        test_branch();
        test_counter_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_result_stage.md
# alu_result_stage

Registered output stage directly downstream of the datapath ALU in the multi-cycle RISC-V core. It captures the ALU result and its Z/C/V/N flags into the ALUOut holding register using a valid/ready handshake. It presents the held value to the writeback/PC-select logic and evaluates the RISC-V branch condition from the captured flags. It also counts accepted results and flags overruns.

## Interface
- `WIDTH`, default 32: datapath width of result and ALUOut.
- `CNT_W`, default 8: width of the accepted-result counter.

Ports:
- `clk`  in  1: single clock, rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `alu_result`  in  WIDTH: ALU result.
- `alu_z`, `alu_c`, `alu_v`, `alu_n`  in  1 each: ALU flags. `alu_c` = carry out of a + ~b + 1 for subtract.
- `in_valid`  in  1: ALU output is valid this cycle (controller's ALU-capture strobe).
- `in_ready`  out  1: stage can accept.
- `is_branch`  in  1: sampled with the capture; the held result belongs to a branch compare.
- `funct3`  in  3: sampled with the capture; branch type.
- `out_valid`  out  1: ALUOut holds an unconsumed result.
- `out_ready`  in  1: consumer accepts the held result.
- `aluout`  out  WIDTH: held result.
- `flags_q`  out  4: held flags {N,Z,C,V}.
- `branch_taken`  out  1: branch condition of the held compare.
- `bad_funct3`  out  1: held branch has funct3 = 010 or 011.
- `overrun`  out  1: sticky; in_valid was high while in_ready was low.
- `clr_overrun`  in  1: synchronous clear of `overrun`.
- `acc_count`  out  CNT_W: number of accepted captures, wraps.

## Operation
- Two-state FSM, EMPTY and FULL. Reset state is EMPTY.
- `in_ready` = (state == EMPTY) | `out_ready`. It is combinational and has no dependence on `in_valid`.
- Capture occurs when `in_valid & in_ready`. It loads `aluout`, `flags_q`, `is_branch`, `funct3`, increments `acc_count` (modulo 2^CNT_W), and puts the FSM in FULL.
- In FULL with `out_ready` and no capture, the FSM goes to EMPTY. Held registers keep their last value.
- Simultaneous consume and capture in FULL: the new value replaces the old one, the FSM stays FULL, and no bubble is inserted.
- `out_valid` = (state == FULL).
- Overrun: `in_valid & ~in_ready` sets `overrun`; the data is dropped and the held value is untouched.
  - `clr_overrun` clears the flag.
  - If set and clear occur in the same cycle, set wins.
- Branch evaluation is combinational from held registers and is valid only while `out_valid & is_branch`. Otherwise `branch_taken` = 0.
  - 000 BEQ: Z.
  - 001 BNE: ~Z.
  - 100 BLT: N^V.
  - 101 BGE: ~(N^V).
  - 110 BLTU: ~C.
  - 111 BGEU: C.
  - 010/011: `branch_taken` = 0 and `bad_funct3` = 1.
- `bad_funct3` = 0 whenever the stage is not holding a branch.

## Timing
- Capture-to-output latency is 1 cycle. Data sampled at edge k appears on `aluout` and `out_valid` after edge k.
- `branch_taken` and `bad_funct3` are valid in the same cycle as `out_valid`, with no extra register.
- Throughput is 1 result/cycle when `out_ready` is held high.
- Reset values while `reset_n` = 0, asserted at any time including mid-transfer:
  - state EMPTY.
  - `aluout` = 0 and `flags_q` = 0.
  - `out_valid` = 0.
  - `branch_taken` = 0 and `bad_funct3` = 0.
  - `overrun` = 0.
  - `acc_count` = 0.
  - `in_ready` = 1.
- A held result is discarded by reset.
- Deassertion is asynchronous. The first capture is possible on the first rising edge after release.

## Configuration
- Macro `ALURES_BRANCH_EN`.
- When defined: branch evaluation is built as specified, and the `is_branch` and `funct3` registers exist.
- When undefined: no branch logic or registers. `branch_taken` and `bad_funct3` are tied to 0, and `is_branch` and `funct3` are ignored. Capture, handshake, counter and overrun behaviour are identical.

## Test plan
- Reset: assert `reset_n` = 0 mid-FULL with `aluout` = 0xDEADBEEF. Required: `out_valid` = 0, `aluout` = 0, `acc_count` = 0, `in_ready` = 1 immediately, with no clock.
- Single capture: `alu_result` = 0x12345678, flags {N,Z,C,V} = 0010, `in_valid` 1 cycle, `out_ready` = 0. Required next cycle: `out_valid` = 1, `aluout` = 0x12345678, `flags_q` = 0010, `in_ready` = 0, `acc_count` = 1.
- Back-to-back streaming: `out_ready` = 1, then 4 consecutive captures 1, 2, 3, 4. Required: `aluout` shows 1, 2, 3, 4 on successive cycles, `out_valid` is continuous, `acc_count` = 4, `overrun` = 0.
- Overrun: FULL with `out_ready` = 0, `in_valid` with 0x55. Required: `aluout` unchanged, `overrun` = 1 and stays 1 until `clr_overrun`. `clr_overrun` together with another overrun leaves `overrun` = 1.
- Branches (macro on): compare a = 0xFFFFFFFF, b = 1 via the ALU, which gives N = 1, C = 1, V = 0, Z = 0.
  - BLT (100) → taken 1.
  - BLTU (110) → 0.
  - BGEU (111) → 1.
  - BEQ (000) → 0.
  - funct3 = 011 → taken 0, `bad_funct3` = 1.
- Counter wrap: 256 captures with CNT_W = 8. Required: `acc_count` returns to 0. With the macro off, `branch_taken` = 0 for the same BGEU compare.
